// File: rtl/pool_pkg.sv
// Shared types and geometry for the max-pool tile scheduler.
package pool_pkg;

  // Controller states for one pass over the feature map.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam int PIX_W  = 8;
  localparam int TILE   = 4;
  localparam int ROW_W  = TILE * PIX_W;
  localparam int TILE_W = TILE * ROW_W;

  // Phase value at which the final row of a tile is captured.
  localparam logic [2:0] FETCH_LAST = 3'(TILE);

endpackage

// File: rtl/pool_tile_scheduler.sv
// Walks a feature map in 4x4 tiles, feeds each tile to the 2x2 max-pool
// engine and writes the pooled word back to SRAM.
module pool_tile_scheduler
  import pool_pkg::*;
#(
  parameter int MAP_W  = 8,
  parameter int MAP_H  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ROW_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ROW_W-1:0]  wr_data,
  output logic              pool_start,
  output logic [TILE_W-1:0] pool_in,
  input  logic              pool_done,
  input  logic [ROW_W-1:0]  pool_out
);

  localparam int WPR       = MAP_W / TILE;
  localparam int TILE_ROWS = MAP_H / TILE;

  state_t            state, state_n;
  logic [2:0]        phase, phase_n;
  logic [ADDR_W-1:0] tr, tr_n, tc, tc_n;
  logic [ADDR_W-1:0] in_base_q, in_base_n, out_base_q, out_base_n;
  logic              take_result;
  logic              last_tile;
  logic              rd_en_n;
  logic [ADDR_W-1:0] rd_off, rd_addr_n, wr_addr_n;
  logic              wr_en_q;
  logic [ROW_W-1:0]  rows [TILE];

  assign last_tile = (tc == ADDR_W'(WPR - 1)) && (tr == ADDR_W'(TILE_ROWS - 1));

  // Next-state, counter and base-address decisions; abort overrides everything.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    tr_n        = tr;
    tc_n        = tc;
    in_base_n   = in_base_q;
    out_base_n  = out_base_q;
    take_result = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n    = FETCH;
          phase_n    = 3'd0;
          tr_n       = '0;
          tc_n       = '0;
          in_base_n  = in_base;
          out_base_n = out_base;
        end
      end
      FETCH: begin
        if (phase == FETCH_LAST) begin
          state_n = START;
          phase_n = 3'd0;
        end else begin
          phase_n = phase + 3'd1;
        end
      end
      START: begin
        if (pool_start) state_n = WAIT;
      end
      WAIT: begin
        if (pool_done) begin
          state_n     = WRITE;
          take_result = 1'b1;
        end
      end
      WRITE: begin
        if (tc == ADDR_W'(WPR - 1)) begin
          tc_n = '0;
          tr_n = tr + 1'b1;
        end else begin
          tc_n = tc + 1'b1;
        end
        phase_n = 3'd0;
        state_n = last_tile ? DONE : FETCH;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_n     = IDLE;
      take_result = 1'b0;
    end
  end

  // Address arithmetic for the upcoming read and for the current tile's result.
  always_comb begin
    rd_en_n   = (state_n == FETCH) && (phase_n != FETCH_LAST);
    rd_off    = ADDR_W'((32'(tr_n) * 32'(TILE) + 32'(phase_n)) * 32'(WPR));
    rd_addr_n = rd_en_n ? (in_base_n + rd_off + tc_n) : '0;
    wr_addr_n = out_base_q + ADDR_W'(32'(tr) * 32'(WPR)) + tc;
  end

  // State, phase, tile counters and latched base addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= 3'd0;
      tr         <= '0;
      tc         <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      tr         <= tr_n;
      tc         <= tc_n;
      in_base_q  <= in_base_n;
      out_base_q <= out_base_n;
    end
  end

  // Registered strobes and addresses, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pool_start <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      busy       <= state_n inside {FETCH, START, WAIT, WRITE};
      done       <= (state_n == DONE);
      rd_en      <= rd_en_n;
      rd_addr    <= rd_addr_n;
      pool_start <= (state_n == START) && !pool_done;
      wr_en_q    <= (state_n == WRITE);
      if (take_result) begin
        wr_addr <= wr_addr_n;
        wr_data <= pool_out;
      end
    end
  end

  // Row capture: the word read in phase k arrives and is stored in phase k+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TILE; i++) rows[i] <= '0;
    end else if ((state == FETCH) && (phase != 3'd0)) begin
      rows[2'(phase - 3'd1)] <= rd_data;
    end
  end

  assign pool_in = {rows[3], rows[2], rows[1], rows[0]};

  // An abort arriving during the write cycle cancels that write.
  assign wr_en = wr_en_q & ~abort;

endmodule

// File: tb/tb_pool_tile_scheduler.sv
// Scoreboard bench for pool_tile_scheduler with SRAM and pool-engine models.
module tb_pool_tile_scheduler;

  localparam int MAP_W  = 8;
  localparam int MAP_H  = 8;
  localparam int ADDR_W = 8;
  localparam int WPR    = MAP_W / 4;
  localparam int NTILES = WPR * (MAP_H / 4);

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [7:0]   in_base, out_base;
  logic         busy, done, rd_en, wr_en, pool_start, pool_done;
  logic [7:0]   rd_addr, wr_addr;
  logic [31:0]  rd_data, wr_data, pool_out;
  logic [127:0] pool_in;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic [31:0]  mem [256];
  logic [7:0]   rd_q[$];
  wr_exp_t      wr_q[$];
  int           vectors = 0, miscompares = 0;
  int           wr_count = 0, done_count = 0, ps_count = 0;
  int           lat_lo = 1, lat_hi = 4, hold_len = 1;
  int           eng_cnt = 0, eng_hold = 0;
  logic [127:0] eng_tile;

  pool_tile_scheduler #(.MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_base(in_base), .out_base(out_base), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pool_start(pool_start), .pool_in(pool_in),
    .pool_done(pool_done), .pool_out(pool_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flagUnexpected(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: strobe seen with nothing expected", name);
  endtask

  // Pixel (x,y) of the map stored at base ib, straight from the memory image.
  function automatic logic [7:0] pix(input logic [7:0] ib, input int x, input int y);
    logic [31:0] w;
    w = mem[8'(int'(ib) + y * WPR + x / 4)];
    return w[8*(x%4) +: 8];
  endfunction

  // Expected pooled word for tile (tr,tc): byte 3 is top-left, byte 0 bottom-right.
  function automatic logic [31:0] refPool(input logic [7:0] ib, input int tr, input int tc);
    logic [31:0] res;
    logic [7:0]  m, v;
    res = '0;
    for (int py = 0; py < 2; py++)
      for (int px = 0; px < 2; px++) begin
        m = 8'd0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            v = pix(ib, 4*tc + 2*px + dx, 4*tr + 2*py + dy);
            if (v > m) m = v;
          end
        res[8*(3 - (2*py + px)) +: 8] = m;
      end
    return res;
  endfunction

  // Engine's own view: pool the 128-bit tile it was handed.
  function automatic logic [31:0] poolTile(input logic [127:0] t);
    logic [31:0] res;
    logic [7:0]  m, v;
    res = '0;
    for (int py = 0; py < 2; py++)
      for (int px = 0; px < 2; px++) begin
        m = 8'd0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            v = t[32*(2*py + dy) + 8*(2*px + dx) +: 8];
            if (v > m) m = v;
          end
        res[8*(3 - (2*py + px)) +: 8] = m;
      end
    return res;
  endfunction

  // Synchronous SRAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Pool engine: random latency, result held for hold_len cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pool_done <= 1'b0;
      pool_out  <= '0;
      eng_cnt = 0;
      eng_hold = 0;
    end else if (pool_start) begin
      eng_tile = pool_in;
      eng_cnt = int'($urandom_range(lat_hi, lat_lo));
      eng_hold = 0;
      pool_done <= 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        pool_done <= 1'b1;
        pool_out  <= poolTile(eng_tile);
        eng_hold = hold_len;
      end
    end else if (eng_hold > 0) begin
      eng_hold--;
      if (eng_hold == 0) pool_done <= 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every read and write strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_en) begin
        if (rd_q.size() == 0) flagUnexpected("rd_extra");
        else checkOutput("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (wr_en) begin
        wr_count++;
        if (wr_q.size() == 0) flagUnexpected("wr_extra");
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          checkOutput("wr_addr", wr_addr, e.addr);
          checkOutput("wr_data", wr_data, e.data);
        end
      end
      if (pool_start) begin
        ps_count++;
        checkOutput("start_while_done", pool_done, 1'b0);
      end
      if (done) done_count++;
    end
  end

  // Push expected reads for the first nrd tiles and writes for the first nwr.
  task automatic pushPass(input logic [7:0] ib, input logic [7:0] ob, input int nrd, input int nwr);
    wr_exp_t e;
    for (int t = 0; t < NTILES; t++) begin
      if (t < nrd)
        for (int r = 0; r < 4; r++)
          rd_q.push_back(8'(int'(ib) + (4*(t/WPR) + r) * WPR + t % WPR));
      if (t < nwr) begin
        e.addr = 8'(int'(ob) + t);
        e.data = refPool(ib, t / WPR, t % WPR);
        wr_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ib, input logic [7:0] ob);
    @(negedge clk);
    in_base  = ib;
    out_base = ob;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_base  = 8'($urandom);
    out_base = 8'($urandom);
  endtask

  task automatic waitDone(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_rd_en"}, rd_en, 1'b0);
    checkOutput({tag, "_rd_addr"}, rd_addr, 8'h00);
    checkOutput({tag, "_wr_en"}, wr_en, 1'b0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 8'h00);
    checkOutput({tag, "_wr_data"}, wr_data, 32'h0);
    checkOutput({tag, "_pool_start"}, pool_start, 1'b0);
    checkOutput({tag, "_pool_in"}, pool_in, 128'h0);
  endtask

  task automatic finishPass(input int d0, input int w0);
    bit seen;
    waitDone(600, seen);
    checkOutput("done_seen", seen, 1'b1);
    checkOutput("busy_at_done", busy, 1'b0);
    @(negedge clk);
    checkOutput("done_pulses", done_count - d0, 1);
    checkOutput("write_total", wr_count - w0, NTILES);
    checkOutput("wr_q_left", wr_q.size(), 0);
    checkOutput("rd_q_left", rd_q.size(), 0);
    checkOutput("done_width", done, 1'b0);
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic runPass(input logic [7:0] ib, input logic [7:0] ob);
    int d0, w0;
    d0 = done_count;
    w0 = wr_count;
    pushPass(ib, ob, NTILES, NTILES);
    applyStimulus(ib, ob);
    finishPass(d0, w0);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  // Runaway guard in case a strobe never arrives.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  d0, w0, p0;
    bit  hit;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_base  = '0;
    out_base = '0;
    rd_data  = '0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;

    // Directed map pixel(x,y) = y*8+x; tile0 pools to 0x090B191B.
    fillRandom();
    for (int y = 0; y < MAP_H; y++)
      for (int x = 0; x < MAP_W; x++)
        mem[y*WPR + x/4][8*(x%4) +: 8] = 8'(y*8 + x);
    runPass(8'h00, 8'h40);

    // Engine holds pool_done for several cycles after each result.
    hold_len = 3;
    runPass(8'h00, 8'h40);
    hold_len = 10;
    fillRandom();
    runPass(8'($urandom), 8'($urandom));
    hold_len = 1;

    // Read addresses wrap past the top of the address space.
    fillRandom();
    runPass(8'hFE, 8'($urandom));

    // Abort during tile1's wait: only tile0 is written, no done.
    lat_lo = 6;
    lat_hi = 6;
    fillRandom();
    in_base = 8'($urandom);
    out_base = 8'($urandom);
    pushPass(in_base, out_base, 2, 1);
    d0 = done_count;
    p0 = ps_count;
    applyStimulus(in_base, out_base);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ps_count >= p0 + 2) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("abort_reached_tile1", hit, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_rd_en", rd_en, 1'b0);
    checkOutput("abort_pool_start", pool_start, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", done_count - d0, 0);
    checkOutput("abort_wr_q_left", wr_q.size(), 0);
    checkOutput("abort_rd_q_left", rd_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    lat_lo = 1;
    lat_hi = 4;
    runPass(8'($urandom), 8'($urandom));

    // A start pulse during tile2's fetch must be ignored.
    fillRandom();
    d0 = done_count;
    w0 = wr_count;
    in_base = 8'($urandom);
    out_base = 8'($urandom);
    pushPass(in_base, out_base, NTILES, NTILES);
    applyStimulus(in_base, out_base);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_count >= w0 + 2) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("reached_tile2", hit, 1'b1);
    in_base = 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finishPass(d0, w0);

    // Reset landing in tile0's write cycle clears everything at once.
    fillRandom();
    in_base = 8'($urandom);
    out_base = 8'($urandom);
    pushPass(in_base, out_base, 1, 1);
    applyStimulus(in_base, out_base);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_en) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("reached_tile0_write", hit, 1'b1);
    #1 reset = 1'b1;
    #1 checkReset("midreset");
    rd_q.delete();
    wr_q.delete();
    d0 = done_count;
    w0 = wr_count;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_no_write", wr_count - w0, 0);
    checkOutput("post_reset_no_done", done_count - d0, 0);
    checkOutput("post_reset_busy", busy, 1'b0);

    // Randomized passes with varying engine timing.
    for (int n = 0; n < 3; n++) begin
      fillRandom();
      hold_len = int'($urandom_range(3, 1));
      runPass(8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pool_tile_scheduler.md
Name: pool_tile_scheduler

Overview:
- Sequences the 2x2 max-pool engine across a full feature map held in on-chip SRAM.
- Walks the map in 4x4-pixel tiles and fetches each tile as four 32-bit row words.
- Hands each tile to the engine via start/done, then writes the 32-bit pooled result back to SRAM.
- Sits between the layer controller (start/done, base addresses) and the SRAM plus pool engine.

Parameters:
- MAP_W, 8, input map width in pixels; multiple of 4, ≥4.
- MAP_H, 8, input map height in pixels; multiple of 4, ≥4.
- ADDR_W, 8, SRAM word-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  1-cycle pulse; begins a map pass; ignored while busy
- abort  in  1  synchronous; cancels the pass
- in_base  in  ADDR_W  input map base word address; sampled on accepted start
- out_base  in  ADDR_W  output base word address; sampled on accepted start
- busy  out  1  high from the cycle after accepted start until DONE or abort
- done  out  1  1-cycle pulse at pass completion
- rd_en  out  1  SRAM read strobe
- rd_addr  out  ADDR_W  SRAM read address
- rd_data  in  32  SRAM read data; valid the cycle after rd_en
- wr_en  out  1  SRAM write strobe
- wr_addr  out  ADDR_W  SRAM write address
- wr_data  out  32  SRAM write data
- pool_start  out  1  1-cycle pulse to the engine
- pool_in  out  128  tile to the engine
- pool_done  in  1  engine completion; level, may stay high ≥1 cycle
- pool_out  in  32  engine result; valid while pool_done=1

Behaviour:
- Reset: state IDLE. All outputs 0, including busy, done, rd_en, wr_en, pool_start, addresses, pool_in and wr_data. Tile counters are 0.
- Memory layout: row-major, MAP_W/4 words per row (WPR). Pixel x of a row sits in bits [8*(x%4)+:8] of its word.
- Tile order: tr = 0..MAP_H/4-1 (outer), tc = 0..WPR-1 (inner).
- Row r of tile (tr,tc) is read from in_base + (4*tr+r)*WPR + tc, for r = 0..3.
- Row r's word is placed in pool_in[32*r+:32].
- Result for tile index t = tr*WPR+tc is written to out_base + t, with wr_data = pool_out unchanged.
- All address arithmetic is modulo 2^ADDR_W; wrap is silent.
- IDLE → FETCH on start. Latch bases, clear counters; busy rises next cycle.
- FETCH: 5 cycles, phase k = 0..4.
  - k = 0..3: rd_en=1, rd_addr = row k.
  - k = 1..4: capture rd_data into row k-1.
  - k = 4 → START.
- START: wait while pool_done=1, so a stale done is not taken as completion. Otherwise pulse pool_start for one cycle → WAIT.
- pool_in is held stable from START through WAIT exit.
- WAIT: on the first cycle pool_done=1, capture pool_out → WRITE. There is no timeout.
- WRITE: wr_en=1 for one cycle. Then advance tc, wrapping to 0 and incrementing tr. Last tile → DONE, else FETCH.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Per-tile cost: 5 + 1 + L + 1 cycles, where L is the engine's start-to-done latency.
- abort from any non-IDLE state → IDLE next cycle. busy=0; no done pulse; no further rd_en, wr_en or pool_start. An abort in the same cycle as WRITE suppresses that write.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Reset mid-pass returns immediately to the reset state. No write or done is issued.
- Strobes (rd_en, wr_en, pool_start, done) are registered outputs and are 0 outside their states.

Decomposition:
- Shared package pool_pkg:
  - state encoding constants (IDLE, FETCH, START, WAIT, WRITE, DONE);
  - PIX_W=8, TILE=4, ROW_W=32, TILE_W=128.
- Optional sub-module pool_tile_addr_gen: tr/tc counters plus read/write address arithmetic, with last_tile flag.
- FSM and tile assembly stay in the top module.

Test Plan:
- Map with pixel(x,y)=y*8+x, in_base=0x00, out_base=0x40, reference engine model:
  - tile0 reads 0x00,0x02,0x04,0x06;
  - write 0x40 ← 0x090B191B;
  - tile1 reads 0x01,0x03,0x05,0x07 → 0x40+1 ← 0x0D0F1D1F;
  - 4 writes in order, one done pulse, busy low after.
- Engine model holding pool_done high 3 cycles after each result → exactly one write per tile; next pool_start only after pool_done falls.
- in_base=0xFE → row addresses wrap to 0xFE,0x00,0x02,0x04 with no error.
- abort asserted during tile1 WAIT → no write at 0x41, no done, busy=0 next cycle; a following start runs a full 4-tile pass correctly.
- start pulsed during FETCH of tile2 → ignored; total writes = 4, single done.
- reset asserted in WRITE cycle of tile0 → wr_en=0 immediately; all outputs 0; state IDLE.
